// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter and its round-robin picker.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping around. Shared by the data- and instruction-memory arbiters.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    // Scan N candidates starting at rr_ptr; the first hit wins.
    always_comb begin
        int cand;
        cand   = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory among NUM_CORES cores.
// One transaction at a time: IDLE picks a winner, ACCESS strobes memory,
// WAIT covers read latency, DONE pulses the winner's ack.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    output logic [NUM_CORES-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
);

    localparam int IDX_W = idx_w(NUM_CORES);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e             state_q,     state_d;
    logic [IDX_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]       win_q,       win_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [NUM_CORES-1:0]   ack_q,       ack_d;
    logic [DATA_W-1:0]      rdata_q,     rdata_d;
    logic                   mem_en_q,    mem_en_d;
    logic                   mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   busy_q,      busy_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_CORES-1:0]   win_onehot;

    rr_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign win_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_q;

    // Next-state and next-output logic; every memory-side output is a flop,
    // so requests never reach the memory pins combinationally.
    always_comb begin
        int unsigned sel;
        sel         = int'(pick_idx);
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    win_d       = pick_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[sel];
                    mem_addr_d  = addr[sel*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[sel*DATA_W +: DATA_W];
                    busy_d      = 1'b1;
                end
            end
            ACCESS: begin
                // mem_we_q still holds the latched write flag in this cycle.
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d = DONE;
                    ack_d   = win_onehot;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(MEM_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                    ack_d   = win_onehot;
                end
            end
            DONE: begin
                state_d  = IDLE;
                ack_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (win_q == IDX_W'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance with MEM_LAT=1 backed by a
// small memory model, one with MEM_LAT=3 backed by a latency pipeline.
module tb_dm_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;

    logic [NC-1:0]    req, we, ack;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_en, mem_we, busy;

    logic [NC-1:0]    req3, we3, ack3;
    logic [NC*AW-1:0] addr3;
    logic [NC*DW-1:0] wdata3;
    logic [DW-1:0]    rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0]    mem_addr3;
    logic             mem_en3, mem_we3, busy3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    dm_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .ack(ack3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .busy(busy3)
    );

    // Latency-1 memory: data valid the cycle after the read strobe, 0xEE otherwise.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_q;
    logic          rd_vld = 1'b0;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        rd_vld <= mem_en && !mem_we;
        rd_q   <= mem[mem_addr[7:0]];
    end
    assign mem_rdata = rd_vld ? rd_q : 8'hEE;

    // Latency-3 memory: returns addr^0x5A exactly three cycles after the strobe.
    logic [DW-1:0] d1, d2, d3;
    logic          p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    always @(posedge clk) begin
        p1 <= mem_en3 && !mem_we3;
        d1 <= mem_addr3[7:0] ^ 8'h5A;
        p2 <= p1;
        d2 <= d1;
        p3 <= p2;
        d3 <= d2;
    end
    assign mem_rdata3 = p3 ? d3 : 8'hEE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ack fires (bounded), then compare it with the expected one-hot.
    task automatic wait_ack(input string tag, input logic [NC-1:0] exp);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ack != '0) begin
                check(tag, 32'(ack), 32'(exp));
                return;
            end
        end
        check({tag, "_timeout"}, 32'(ack), 32'(exp));
    endtask

    initial begin
        int en_pulses;
        rst = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
        tick();
        tick();
        check("rst_ack",       32'(ack),       32'h0);
        check("rst_rdata",     32'(rdata),     32'h0);
        check("rst_mem_en",    32'(mem_en),    32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_busy3",     32'(busy3),     32'h0);
        rst = 1'b0;
        tick();

        // Core 1 writes 0xA5 to 0x0010.
        req = 4'b0010; we = 4'b0010;
        addr[1*AW +: AW] = 16'h0010; wdata[1*DW +: DW] = 8'hA5;
        tick();
        check("wr_mem_en",    32'(mem_en),    32'h1);
        check("wr_mem_we",    32'(mem_we),    32'h1);
        check("wr_mem_addr",  32'(mem_addr),  32'h0010);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        check("wr_busy_t1",   32'(busy),      32'h1);
        check("wr_ack_t1",    32'(ack),       32'h0);
        tick();
        check("wr_ack",       32'(ack),       32'h2);
        check("wr_busy_t2",   32'(busy),      32'h1);
        check("wr_mem_en_t2", 32'(mem_en),    32'h0);
        req = '0; we = '0;
        tick();
        check("wr_idle_busy", 32'(busy),      32'h0);
        check("wr_idle_ack",  32'(ack),       32'h0);

        // Core 2 reads 0x0010 back.
        req = 4'b0100; addr[2*AW +: AW] = 16'h0010;
        tick();
        check("rd_mem_en",   32'(mem_en),   32'h1);
        check("rd_mem_we",   32'(mem_we),   32'h0);
        check("rd_mem_addr", 32'(mem_addr), 32'h0010);
        tick();
        check("rd_ack_t2",   32'(ack),      32'h0);
        tick();
        check("rd_ack",      32'(ack),      32'h4);
        check("rd_rdata",    32'(rdata),    32'hA5);
        req = '0;
        tick();

        // Core 1 read, reset asserted while in WAIT.
        req = 4'b0010; we = 4'b0000; addr[1*AW +: AW] = 16'h0033; wdata[1*DW +: DW] = 8'h3C;
        tick();
        check("rw_mem_addr", 32'(mem_addr), 32'h0033);
        tick();
        rst = 1'b1;
        tick();
        check("rw_ack",       32'(ack),       32'h0);
        check("rw_busy",      32'(busy),      32'h0);
        check("rw_mem_en",    32'(mem_en),    32'h0);
        check("rw_mem_addr0", 32'(mem_addr),  32'h0);
        check("rw_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rw_rdata",     32'(rdata),     32'h0);
        rst = 1'b0;
        req = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rw_no_ack", 32'(ack), 32'h0);
        end

        // All four cores read 0x0010 continuously; grants must rotate 0,1,2,3,0.
        req = 4'hF; we = '0; addr = {NC{16'h0010}};
        for (int n = 0; n < 5; n++) begin
            wait_ack("rr_grant", 4'b0001 << (n % 4));
            check("rr_rdata", 32'(rdata), 32'hA5);
            if (n == 4) req = '0;
        end
        tick();
        check("rr_idle_busy", 32'(busy), 32'h0);

        // Core 3 drops req right after being latched; still gets its ack.
        req = 4'b1000; addr[3*AW +: AW] = 16'h0010;
        tick();
        check("drop_mem_en", 32'(mem_en), 32'h1);
        req = '0;
        tick();
        check("drop_ack_t2", 32'(ack),   32'h0);
        tick();
        check("drop_ack",    32'(ack),   32'h8);
        check("drop_rdata",  32'(rdata), 32'hA5);
        tick();
        check("drop_busy_a", 32'(busy),  32'h0);
        tick();
        check("drop_busy_b", 32'(busy),  32'h0);
        check("drop_mem_en_idle", 32'(mem_en), 32'h0);

        // MEM_LAT=3 instance: core 0 reads 0x0044, expect 0x44^0x5A at t+5.
        req3 = 4'b0001; we3 = '0; addr3[0 +: AW] = 16'h0044;
        en_pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (mem_en3) en_pulses++;
            if (c == 1) check("l3_mem_en_t1", 32'(mem_en3), 32'h1);
            if (c < 5)  check("l3_no_ack",    32'(ack3),    32'h0);
            if (c == 5) begin
                check("l3_ack",   32'(ack3),   32'h1);
                check("l3_rdata", 32'(rdata3), 32'h1E);
                req3 = '0;
            end
        end
        check("l3_en_pulses", 32'(en_pulses), 32'h1);
        tick();
        check("l3_idle_busy", 32'(busy3), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Round-robin arbiter and sequencer that shares one 8-bit data memory between several processor cores in the matrix-multiplication array. Each core presents a word-wide request (address, write flag, write data); the arbiter grants one at a time, drives the memory strobe for exactly one cycle, waits out the memory read latency, and returns a one-cycle completion pulse with read data. It sits between the cores' `dm_en` and address/bus outputs and the single data-memory instance.

## Interface
- `NUM_CORES`, 4: number of requesters, ≥2.
- `ADDR_W`, 16: memory address width; matches the processor address register.
- `DATA_W`, 8: memory data width.
- `MEM_LAT`, 1: read latency in cycles from the `mem_en` cycle to valid `mem_rdata`, ≥1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_CORES  per-core request; held until that core's `ack`.
- `we`  in  NUM_CORES  per-core write flag (1 = write, 0 = read).
- `addr`  in  NUM_CORES*ADDR_W  packed per-core addresses; core i at [i*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_CORES*DATA_W  packed per-core write data.
- `ack`  out  NUM_CORES  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  read data; valid in the `ack` cycle of a read.
- `mem_en`  out  1  memory strobe, one cycle per transaction.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any `req` is high, select the winner round-robin starting at `rr_ptr`. Latch the winner index, `we`, `addr` and `wdata`. Go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched values. A write goes to DONE. A read loads the latency counter with MEM_LAT and goes to WAIT.
- WAIT: decrement the counter each cycle. In the final WAIT cycle (counter = 1), capture `mem_rdata` into `rdata` and go to DONE.
- DONE: `ack[winner]`=1 for this one cycle only. Set `rr_ptr` = (winner+1) mod NUM_CORES. Go to IDLE. No arbitration happens in DONE.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable until `ack`, then drop `req` the cycle after `ack`. A `req` still high in the following IDLE is treated as a new transaction.
- If a core drops `req` after being latched, its transaction still completes and it still receives `ack`.
- Inputs from non-winning cores are ignored while busy.
- `rdata` holds its last captured value until the next read capture. It is undefined-by-contract in the `ack` cycle of a write, but in practice it keeps its previous value.
- Reset values: state=IDLE, `rr_ptr`=0, `ack`=0, `rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0.
- Reset mid-transaction: the transaction is abandoned and no `ack` is issued. A write already strobed in ACCESS stays committed in memory.

## Timing
- `req` first sampled high in IDLE at cycle t:
  - ACCESS at t+1.
  - Write: DONE/`ack` at t+2.
  - Read: WAIT from t+2 to t+1+MEM_LAT, DONE/`ack` at t+2+MEM_LAT.
- Throughput: one write per 3 cycles; one read per 3+MEM_LAT cycles.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `ack` and `busy` are decoded from registered state and latched fields only. There is no combinational path from `req`/`addr` to the memory-side outputs.
- Simultaneous requests: only one is granted per IDLE visit. Fairness bound: any held request is granted within NUM_CORES transactions.

## Structure
- Package `dm_arb_pkg`:
  - state enum: IDLE, ACCESS, WAIT, DONE.
  - default width constants: ADDR_W=16, DATA_W=8.
  - `$clog2`-based index width helper.
- Sub-module `rr_picker`: combinational. Inputs are `req` and `rr_ptr`. Outputs are `valid` and the winner index, found by searching from `rr_ptr` upward with wrap-around. It is reusable for the instruction-memory port.

## Test plan
- Reset, then core 1 writes addr 0x0010 with data 0xA5 → `mem_en`/`mem_we` high at t+1 with `mem_addr`=0x0010 and `mem_wdata`=0xA5; `ack`=4'b0010 at t+2; `busy` high for t+1..t+2.
- Core 2 reads 0x0010 with MEM_LAT=1 and memory returning 0xA5 → `mem_en`=1, `mem_we`=0 at t+1; `ack`=4'b0100 and `rdata`=0xA5 at t+3.
- All four cores request reads in the same cycle and keep re-requesting → grant order 0,1,2,3,0; no core waits more than 4 transactions.
- MEM_LAT=3, single read → `ack` at t+5; exactly one `mem_en` pulse; `mem_rdata` captured only at t+4.
- `rst` asserted while in WAIT → next cycle state=IDLE, `rr_ptr`=0, all outputs 0, no `ack` ever issued for that read.
- Winner drops `req` during WAIT → `ack` still pulses for it; with no other requests, `busy` stays low after DONE.
